// File: rtl/cnc_mag_unit.sv
// ---------------------------------------------------------------------------
// cnc_mag_unit
//
// Purpose:
//   Takes two-cycle result bursts (real word, then imaginary word) from the
//   complex calculator stage. Computes re^2 + im^2 with a single shared
//   17x17 signed multiplier over two cycles. Queues the magnitudes in a
//   small result FIFO for a valid/ready consumer.
//
// Configuration:
//   CNC_MAG_SAT_EN - when defined, any magnitude above 32'hFFFF_FFFF is
//                    written to the FIFO as 34'h0_FFFF_FFFF. When undefined
//                    (the default), the exact 34-bit sum is written.
//
// Parameters:
//   FIFO_DEPTH - result FIFO entries; a power of two in the range 2..16.
//
// Ports:
//   clk       in   clock; all state updates on the rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   result-burst strobe (two consecutive cycles per pair)
//   in_data   in   17-bit signed word: 1st burst cycle real, 2nd imaginary
//   out_valid out  FIFO head holds a valid magnitude
//   out_ready in   consumer accepts the head when out_valid && out_ready
//   out_data  out  34-bit unsigned magnitude at the FIFO head
//   err_drop  out  sticky flag: a pair or a result was discarded
// ---------------------------------------------------------------------------
module cnc_mag_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [16:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [33:0] out_data,
    output logic        err_drop
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        GET_IM,
        SQ_RE,
        SQ_IM,
        PUSH
    } state_t;

    state_t             state;
    logic signed [16:0] re;
    logic signed [16:0] im;
    logic        [33:0] acc;

    logic signed [33:0] mul_op;
    logic signed [33:0] prod;
    logic        [33:0] wr_data;

    logic [33:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic pop;
    logic push;

    // The single multiplier squares re in SQ_RE and im in SQ_IM. Operands are
    // sign-extended to 34 bits. A square of a 17-bit value is at most 2^32,
    // so the low 34 bits of the product are exact.
    assign mul_op = (state == SQ_IM) ? {{17{im[16]}}, im} : {{17{re[16]}}, re};
    assign prod   = mul_op * mul_op;

`ifdef CNC_MAG_SAT_EN
    // Clamp anything that does not fit in 32 bits.
    assign wr_data = (acc[33:32] != 2'b00) ? 34'h0_FFFF_FFFF : acc;
`else
    assign wr_data = acc;
`endif

    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign push      = (state == PUSH) && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Burst sequencing and the two-step squaring datapath.
    // A burst is only recognised from IDLE. Strobes that arrive while a pair is
    // being squared or pushed are ignored and reported via err_drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            re       <= '0;
            im       <= '0;
            acc      <= '0;
            err_drop <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        re    <= in_data;
                        state <= GET_IM;
                    end
                end
                GET_IM: begin
                    if (in_valid) begin
                        im    <= in_data;
                        state <= SQ_RE;
                    end else begin
                        err_drop <= 1'b1;
                        state    <= IDLE;
                    end
                end
                SQ_RE: begin
                    acc   <= $unsigned(prod);
                    state <= SQ_IM;
                    if (in_valid) begin
                        err_drop <= 1'b1;
                    end
                end
                SQ_IM: begin
                    acc   <= acc + $unsigned(prod);
                    state <= PUSH;
                    if (in_valid) begin
                        err_drop <= 1'b1;
                    end
                end
                PUSH: begin
                    state <= IDLE;
                    if (in_valid || (full && !pop)) begin
                        err_drop <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy. The pointers are exactly log2(depth) bits
    // wide, so they wrap naturally. A push and a pop in the same cycle leave
    // the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. It needs no reset, because out_data is forced to zero
    // whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_cnc_mag_unit.sv
// ---------------------------------------------------------------------------
// tb_cnc_mag_unit
//
// Purpose:
//   Self-checking bench for cnc_mag_unit. Stimulus drives bursts and
//   consumer backpressure. A reference model predicts the magnitudes as
//   re*re + im*im, computed with integer arithmetic. Predicted results go
//   into a scoreboard queue. A monitor compares the DUT outputs against the
//   head of that queue and pops it on every accepted handshake.
// ---------------------------------------------------------------------------
module tb_cnc_mag_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [16:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [33:0] out_data;
    logic        err_drop;

    int checks   = 0;
    int failures = 0;
    bit rnd_ready = 1'b0;

    // Reference model state: scoreboard of expected results and the model's
    // view of burst progress, occupancy and the sticky error.
    longint exp_q[$];
    int     occ = 0;
    int     phase = 0;
    bit     err_exp = 1'b0;
    longint m_re = 0;
    longint m_im = 0;

    cnc_mag_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err_drop (err_drop)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Central comparison: every check goes through here.
    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Expected magnitude of a pair, computed with integer arithmetic.
    function automatic longint magnitude(input longint r, input longint i);
        longint v;
        v = r * r + i * i;
`ifdef CNC_MAG_SAT_EN
        if (v > 64'h0000_0000_FFFF_FFFF) v = 64'h0000_0000_FFFF_FFFF;
`endif
        return v;
    endfunction

    // Reference model, advanced on every rising edge. A burst takes two
    // capture cycles plus three busy cycles. The result is offered to the
    // FIFO on the last busy cycle. Strobes seen while busy only raise the
    // error flag.
    always @(posedge clk) begin
        bit pop;
        bit push;
        if (!rst_n) begin
            phase   = 0;
            occ     = 0;
            err_exp = 1'b0;
            exp_q.delete();
        end else begin
            pop  = (occ > 0) && out_ready;
            push = 1'b0;
            case (phase)
                0: if (in_valid) begin m_re = longint'($signed(in_data)); phase = 1; end
                1: if (in_valid) begin
                       m_im = longint'($signed(in_data));
                       phase = 2;
                   end else begin
                       err_exp = 1'b1;
                       phase = 0;
                   end
                2, 3: begin if (in_valid) err_exp = 1'b1; phase++; end
                default: begin if (in_valid) err_exp = 1'b1; push = 1'b1; phase = 0; end
            endcase
            if (push) begin
                if (occ < DEPTH || pop) begin
                    exp_q.push_back(magnitude(m_re, m_im));
                    occ++;
                end else begin
                    err_exp = 1'b1;
                end
            end
            if (pop) occ--;
        end
    end

    // Monitor, sampling on the falling edge: checks presence, head value and
    // the error flag. It pops the scoreboard when the consumer accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("out_valid", longint'(out_valid), longint'(occ > 0));
            checkOutput("err_drop", longint'(err_drop), longint'(err_exp));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out", 1, 0);
                end else begin
                    checkOutput("out_data", longint'(out_data), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus. Inputs change just after the rising edge.
    task automatic step(input logic v, input logic [16:0] d);
        in_valid = v;
        in_data  = d;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    // One complete burst followed by the three busy cycles.
    task automatic applyStimulus(input logic [16:0] r, input logic [16:0] i);
        step(1'b1, r);
        step(1'b1, i);
        repeat (3) step(1'b0, '0);
    endtask

    // Reset with in_valid asserted, to show that it is ignored during reset.
    task automatic doReset();
        rst_n = 1'b0;
        step(1'b1, 17'd5);
        step(1'b1, 17'd6);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        doReset();
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_out_data", longint'(out_data), 0);
        checkOutput("reset_err_drop", longint'(err_drop), 0);

        // 3, -4 with a ready consumer. The result is visible from c5.
        out_ready = 1'b1;
        step(1'b1, 17'd3);
        step(1'b1, -17'sd4);
        repeat (3) step(1'b0, '0);
        checkOutput("lat_c5_valid", longint'(out_valid), 1);
        checkOutput("lat_c5_data", longint'(out_data), 25);
        step(1'b0, '0);
        checkOutput("lat_c6_valid", longint'(out_valid), 0);

        // Largest magnitude: (-65536)^2 * 2.
        applyStimulus(-17'sd65536, -17'sd65536);
        repeat (2) step(1'b0, '0);

        // Five pairs into a four-deep FIFO, then drain in order.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) applyStimulus(17'(k), 17'(k + 10));
        out_ready = 1'b1;
        repeat (8) step(1'b0, '0);

        // Lone strobe: the pair is abandoned.
        doReset();
        step(1'b1, 17'd7);
        repeat (4) step(1'b0, '0);

        // Reset during the second squaring cycle, with two results queued.
        doReset();
        out_ready = 1'b0;
        applyStimulus(17'd2, 17'd3);
        applyStimulus(17'd4, 17'd5);
        step(1'b1, 17'd9);
        step(1'b1, 17'd9);
        step(1'b0, '0);
        rst_n = 1'b0;
        step(1'b0, '0);
        rst_n = 1'b1;
        checkOutput("rst_mid_valid", longint'(out_valid), 0);
        checkOutput("rst_mid_err", longint'(err_drop), 0);
        out_ready = 1'b1;
        applyStimulus(17'd1, 17'd1);
        repeat (2) step(1'b0, '0);

        // Full FIFO: push and pop in the same cycle with no drop.
        doReset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(17'(k + 1), 17'd0);
        step(1'b1, 17'd5);
        step(1'b1, 17'd12);
        step(1'b0, '0);
        step(1'b0, '0);
        out_ready = 1'b1;
        repeat (8) step(1'b0, '0);
        checkOutput("full_swap_err", longint'(err_drop), 0);

        // Randomized traffic with random backpressure and stray strobes.
        doReset();
        rnd_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) step(1'b1, 17'($urandom));
            else if ($urandom_range(0, 2) != 0) begin
                step(1'b1, 17'($urandom));
                step(1'b1, 17'($urandom));
            end else step(1'b0, '0);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        repeat (30) step(1'b0, '0);
        checkOutput("final_drained", longint'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnc_mag_unit.md
CNC_MAG_UNIT -- requirements
Module: cnc_mag_unit

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning result FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: result-burst strobe from the complex calculator stage.
REQ-005 The block SHALL have port in_data, input, 17 bits: signed two's-complement word; 1st burst cycle = real, 2nd = imaginary.
REQ-006 The block SHALL have port out_valid, output, 1 bit: FIFO head holds a valid magnitude.
REQ-007 The block SHALL have port out_ready, input, 1 bit: consumer accepts head when out_valid && out_ready.
REQ-008 The block SHALL have port out_data, output, 34 bits: unsigned re^2+im^2 at FIFO head.
REQ-009 The block SHALL have port err_drop, output, 1 bit: sticky flag, a pair or result was discarded.

Function
REQ-010 The FSM SHALL have states IDLE, GET_IM, SQ_RE, SQ_IM, PUSH.
REQ-011 The FSM SHALL go IDLE->GET_IM when in_valid=1, capturing in_data as re.
REQ-012 In GET_IM, in_valid=1 SHALL capture im and go to SQ_RE; in_valid=0 SHALL discard re, set err_drop, and return to IDLE.
REQ-013 The FSM SHALL go SQ_RE->SQ_IM->PUSH->IDLE unconditionally, one cycle each.
REQ-014 The block SHALL use exactly one 17x17 signed multiplier: SQ_RE loads acc=re*re, SQ_IM sets acc=acc+im*im; acc is 34-bit unsigned.
REQ-015 PUSH SHALL write the result into the FIFO if not full; if full, it SHALL discard the result and set err_drop.
REQ-016 in_valid=1 during SQ_RE, SQ_IM or PUSH SHALL be ignored and SHALL set err_drop; no new burst starts until IDLE.
REQ-017 in_valid=1 in PUSH SHALL NOT start a burst; the next burst is recognised only from IDLE.
REQ-018 Latency: with in_valid high in cycles c0 and c1 and an empty FIFO, out_valid SHALL first be 1 in cycle c5.
REQ-019 out_valid SHALL equal FIFO non-empty; out_data SHALL equal head entry, held stable while out_valid=1 and out_ready=0.
REQ-020 out_valid && out_ready SHALL pop one entry per cycle; out_ready while empty SHALL have no effect.
REQ-021 On simultaneous push and pop when full, both SHALL occur with no drop; occupancy is unchanged.
REQ-022 On simultaneous push and pop with one entry, occupancy SHALL stay 1 and the new entry becomes head next cycle.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-024 err_drop SHALL clear only on reset.

Reset
REQ-025 rst_n=0 at a rising edge SHALL set state IDLE, pointers/count 0, acc/re/im 0, out_valid=0, out_data=0, err_drop=0.
REQ-026 Reset mid-burst or mid-computation SHALL abandon the pair with no FIFO write; FIFO contents are flushed.
REQ-027 in_valid during the reset cycle SHALL be ignored.

Configuration
REQ-028 With macro CNC_MAG_SAT_EN defined, a result >32'hFFFF_FFFF SHALL be written as 34'h0_FFFF_FFFF (bits 33:32 always 0).
REQ-029 Without CNC_MAG_SAT_EN, the exact 34-bit sum SHALL be written; the port width is 34 bits in both builds.

Verification
REQ-030 in_data 3 then -4 with out_ready=1 -> out_valid=1 in c5 with out_data=25, out_valid=0 in c6, err_drop=0.
REQ-031 in_data -65536 then -65536 -> out_data=34'h2_0000_0000 without CNC_MAG_SAT_EN, and 34'h0_FFFF_FFFF with it.
REQ-032 Five valid pairs, out_ready=0, FIFO_DEPTH=4 -> 4 entries held, 5th dropped, err_drop=1; then out_ready=1 -> 4 pops in order, out_valid=0 afterwards.
REQ-033 Single-cycle in_valid pulse (in_data=7) followed by idle -> no output, err_drop=1, FSM back in IDLE.
REQ-034 rst_n=0 asserted in SQ_IM of a pair with two entries queued -> next cycle out_valid=0, err_drop=0; new pair 1,1 -> out_data=2.
REQ-035 FIFO full, out_ready=1 held, new pair 5,12 arrives -> PUSH cycle pops and pushes together, no drop, 169 later reaches the head in order.
